led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
- Sequencer for the 4-LED shift/flash output multiplexer.
- Generates the shift and flash patterns from a speed-selectable prescaler.
- Owns the mode state: a button press toggles between SHIFT and FLASH.
- Drives the mux select, so the board top only wires this block's outputs into the mux.

Parameters:
N_LEDS, 4, number of LEDs in each pattern
NB_COUNT, 32, prescaler counter width
LIMIT0, 2**20-1, prescaler terminal count for i_speed_sel=0 (slowest)
LIMIT1, 2**19-1, terminal count for i_speed_sel=1
LIMIT2, 2**18-1, terminal count for i_speed_sel=2
LIMIT3, 2**17-1, terminal count for i_speed_sel=3 (fastest)

Ports:
clock  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-low reset
i_enable  in  1  1 = run; 0 = freeze counter and patterns (sw[0])
i_speed_sel  in  2  selects LIMIT0..LIMIT3 (sw[2:1])
i_dir  in  1  shift direction: 0 = rotate left (toward MSB), 1 = rotate right (sw[3])
i_mode_btn  in  1  mode button, already synchronized/debounced, level
o_mux_sel  out  1  0 = SHIFT, 1 = FLASH; connects to the mux select
o_shift_leds  out  N_LEDS  shift pattern
o_flash_leds  out  N_LEDS  flash pattern
o_tick  out  1  one-cycle pulse on each pattern step

Behaviour:
- Reset is sampled only on the clock edge while i_reset=0. All registers are reset:
  - count=0, o_tick=0, o_mux_sel=0 (SHIFT), o_shift_leds=0001, o_flash_leds=0000.
  - The button-edge register takes the current i_mode_btn value, so a held button does not toggle mode on exit from reset.
- Reset mid-operation wins over every other event on that edge.
- Prescaler:
  - limit = LIMIT[i_speed_sel]; it is decoded combinationally every cycle.
  - When i_enable=1 and count<limit: count increments.
  - When i_enable=1 and count==limit: count is set to 0 and o_tick is registered to 1 on that edge.
  - Resulting tick period is limit+1 cycles.
  - i_enable=0: count holds, o_tick=0, patterns hold.
- Speed change: if count>limit after i_speed_sel changes, count is cleared to 0 on the next edge with no tick. The count never runs past the limit and never wraps through 2**NB_COUNT.
- Pattern step: the pattern update is registered on the same edge that sets o_tick. The new pattern and o_tick=1 are visible in the same cycle, one cycle after count==limit was sampled.
  - SHIFT mode: o_shift_leds rotates by one, left if i_dir=0, right if i_dir=1, with wrap-around (1000 -> 0001 on left, 0001 -> 1000 on right). o_flash_leds holds.
  - FLASH mode: o_flash_leds toggles between 0000 and all ones (1111). o_shift_leds holds.
  - i_dir change takes effect at the next tick.
- Mode FSM: two states, SHIFT(0) and FLASH(1); o_mux_sel is the state register.
  - A rising edge on i_mode_btn (registered previous value 0, current 1) toggles the state.
  - On a toggle: count is cleared to 0, o_shift_leds returns to 0001, o_flash_leds returns to 0000, o_tick=0.
  - The edge is honoured even when i_enable=0.
- Simultaneous mode edge and terminal count: the mode toggle wins. No pattern step and no o_tick; the pattern clear happens.
- Holding the button gives exactly one toggle; release gives none.

Decomposition:
- Shared package holds:
  - Mode encodings SHIFT=1'b0 and FLASH=1'b1, identical to the mux select encoding.
  - Reset pattern constants SHIFT_INIT=0001 and FLASH_INIT=0000.
  - Default LIMIT0..LIMIT3 values.
- One sub-module, led_tick_gen: prescaler with limit select, enable, synchronous clear, and registered tick output.
- Mode FSM, edge detector and pattern registers stay in led_seq_ctrl.

Test Plan:
- Use LIMIT0..3 = 3,2,1,0 for all scenarios.
- Reset and run: i_reset=0 for 2 cycles, then release with i_enable=1, sel=0, dir=0.
  -> Outputs equal the reset values while reset is asserted.
  -> o_tick pulses every 4 cycles.
  -> o_shift_leds steps 0001, 0010, 0100, 1000, 0001.
  -> o_mux_sel=0 throughout.
- Direction and wrap: dir=1 from 0001 -> 1000, 0100, 0010, 0001 on successive ticks.
- Mode toggle: single-cycle button pulse.
  -> Next edge: o_mux_sel=1, o_shift_leds=0001, o_flash_leds=0000, count=0.
  -> Then o_flash_leds alternates 1111 and 0000 every 4 cycles.
  -> A button held high for 20 cycles gives exactly one toggle.
- Speed change and freeze:
  - Switch sel 0 -> 3 while count=2: count clears, then o_tick on every cycle.
  - i_enable=0 for 10 cycles: no o_tick, patterns and count hold.
  - i_enable=1 again: stepping resumes from the held count.
- Collision: button rising edge on the same cycle count==limit.
  -> Mode toggles, patterns go to their reset values, no o_tick that cycle.
- Reset mid-operation: i_reset=0 while in FLASH with o_flash_leds=1111.
  -> Next edge: o_mux_sel=0, o_flash_leds=0000, o_shift_leds=0001, o_tick=0.

Source files
------------

// File: rtl/led_seq_ctrl_pkg.sv
// Shared definitions for the LED shift/flash sequencer: mode encodings
// (identical to the output mux select), pattern reset values and the
// default prescaler terminal counts.
package led_seq_ctrl_pkg;

  // Mode encoding doubles as the mux select: 0 routes the shift pattern,
  // 1 routes the flash pattern.
  typedef enum logic {
    SHIFT = 1'b0,
    FLASH = 1'b1
  } mode_e;

  // Pattern values after reset or a mode toggle (4-LED board encoding;
  // zero-extended when a wider pattern is instantiated).
  localparam logic [3:0] SHIFT_INIT = 4'b0001;
  localparam logic [3:0] FLASH_INIT = 4'b0000;

  // Default prescaler terminal counts, slowest (0) to fastest (3).
  localparam int unsigned LIMIT0_DEF = 2**20 - 1;
  localparam int unsigned LIMIT1_DEF = 2**19 - 1;
  localparam int unsigned LIMIT2_DEF = 2**18 - 1;
  localparam int unsigned LIMIT3_DEF = 2**17 - 1;

endpackage : led_seq_ctrl_pkg

// File: rtl/led_tick_gen.sv
// Speed-selectable prescaler. Counts 0..limit while enabled and emits a
// registered one-cycle tick on the edge where the count wraps back to 0.
// o_term is the combinational "this edge is a pattern step" strobe so the
// parent can register its pattern update on the same edge as o_tick.
module led_tick_gen
  import led_seq_ctrl_pkg::*;
#(
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT0   = LIMIT0_DEF,
  parameter int unsigned LIMIT1   = LIMIT1_DEF,
  parameter int unsigned LIMIT2   = LIMIT2_DEF,
  parameter int unsigned LIMIT3   = LIMIT3_DEF
) (
  input  logic       clock,
  input  logic       i_reset,      // synchronous, active-low
  input  logic       i_enable,
  input  logic       i_clear,      // synchronous clear, beats terminal count
  input  logic [1:0] i_speed_sel,
  output logic       o_term,
  output logic       o_tick
);

  logic [NB_COUNT-1:0] limit;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                tick_q, tick_d;

  // Decode the active terminal count from the speed switches every cycle.
  always_comb begin
    limit = NB_COUNT'(LIMIT0);
    case (i_speed_sel)
      2'd0:    limit = NB_COUNT'(LIMIT0);
      2'd1:    limit = NB_COUNT'(LIMIT1);
      2'd2:    limit = NB_COUNT'(LIMIT2);
      default: limit = NB_COUNT'(LIMIT3);
    endcase
  end

  // Next count and tick: clear wins, then freeze, then an over-limit count
  // (left behind by a speed change) is dropped to 0 without a tick.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    o_term  = 1'b0;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      if (count_q > limit) begin
        count_d = '0;
      end else if (count_q == limit) begin
        count_d = '0;
        tick_d  = 1'b1;
        o_term  = 1'b1;
      end else begin
        count_d = count_q + NB_COUNT'(1);
      end
    end
  end

  // Count and tick registers.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule : led_tick_gen

// File: rtl/led_seq_ctrl.sv
// LED sequencer top: owns the SHIFT/FLASH mode state (toggled by rising
// edges of the debounced mode button), the two pattern registers and the
// mux select. Pattern steps are paced by led_tick_gen.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int          N_LEDS   = 4,
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT0   = LIMIT0_DEF,
  parameter int unsigned LIMIT1   = LIMIT1_DEF,
  parameter int unsigned LIMIT2   = LIMIT2_DEF,
  parameter int unsigned LIMIT3   = LIMIT3_DEF
) (
  input  logic              clock,
  input  logic              i_reset,      // synchronous, active-low
  input  logic              i_enable,
  input  logic [1:0]        i_speed_sel,
  input  logic              i_dir,        // 0 = rotate toward MSB, 1 = toward LSB
  input  logic              i_mode_btn,
  output logic              o_mux_sel,
  output logic [N_LEDS-1:0] o_shift_leds,
  output logic [N_LEDS-1:0] o_flash_leds,
  output logic              o_tick
);

  localparam logic [N_LEDS-1:0] SHIFT_RST = N_LEDS'(SHIFT_INIT);
  localparam logic [N_LEDS-1:0] FLASH_RST = N_LEDS'(FLASH_INIT);

  mode_e             mode_q;
  logic              btn_q;
  logic              btn_rise;
  logic              step;
  logic [N_LEDS-1:0] shift_q, shift_d;
  logic [N_LEDS-1:0] flash_q, flash_d;

  // A toggle needs the registered button low and the live button high, so
  // holding the button produces one toggle and releasing it produces none.
  assign btn_rise = i_mode_btn & ~btn_q;

  // The button edge doubles as the prescaler clear; the tick generator
  // suppresses its terminal-count strobe whenever the clear is active, so a
  // simultaneous edge and terminal count yields the toggle and no step.
  led_tick_gen #(
    .NB_COUNT (NB_COUNT),
    .LIMIT0   (LIMIT0),
    .LIMIT1   (LIMIT1),
    .LIMIT2   (LIMIT2),
    .LIMIT3   (LIMIT3)
  ) u_tick_gen (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_clear     (btn_rise),
    .i_speed_sel (i_speed_sel),
    .o_term      (step),
    .o_tick      (o_tick)
  );

  // Next pattern values: only the pattern belonging to the active mode
  // advances on a step; the other one holds.
  always_comb begin
    shift_d = shift_q;
    flash_d = flash_q;
    if (btn_rise) begin
      shift_d = SHIFT_RST;
      flash_d = FLASH_RST;
    end else if (step) begin
      if (mode_q == SHIFT) begin
        if (i_dir) shift_d = {shift_q[0], shift_q[N_LEDS-1:1]};
        else       shift_d = {shift_q[N_LEDS-2:0], shift_q[N_LEDS-1]};
      end else begin
        flash_d = ~flash_q;
      end
    end
  end

  // Mode FSM, button edge register and pattern registers; reset captures
  // the live button so a button held through reset does not toggle.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      mode_q  <= SHIFT;
      btn_q   <= i_mode_btn;
      shift_q <= SHIFT_RST;
      flash_q <= FLASH_RST;
    end else begin
      btn_q   <= i_mode_btn;
      shift_q <= shift_d;
      flash_q <= flash_d;
      case (mode_q)
        SHIFT:   if (btn_rise) mode_q <= FLASH;
        FLASH:   if (btn_rise) mode_q <= SHIFT;
        default: mode_q <= SHIFT;
      endcase
    end
  end

  assign o_mux_sel    = mode_q;
  assign o_shift_leds = shift_q;
  assign o_flash_leds = flash_q;

endmodule : led_seq_ctrl

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with terminal counts 3,2,1,0.
module tb_led_seq_ctrl;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_speed_sel;
  logic       i_dir;
  logic       i_mode_btn;
  logic       o_mux_sel;
  logic [3:0] o_shift_leds;
  logic [3:0] o_flash_leds;
  logic       o_tick;

  int n_chk  = 0;
  int n_pass = 0;

  led_seq_ctrl #(
    .N_LEDS   (4),
    .NB_COUNT (32),
    .LIMIT0   (3),
    .LIMIT1   (2),
    .LIMIT2   (1),
    .LIMIT3   (0)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_speed_sel  (i_speed_sel),
    .i_dir        (i_dir),
    .i_mode_btn   (i_mode_btn),
    .o_mux_sel    (o_mux_sel),
    .o_shift_leds (o_shift_leds),
    .o_flash_leds (o_flash_leds),
    .o_tick       (o_tick)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic mux, input logic tick,
                         input logic [3:0] sh, input logic [3:0] fl);
    chk({tag, ".mux"},   32'(o_mux_sel),    32'(mux));
    chk({tag, ".tick"},  32'(o_tick),       32'(tick));
    chk({tag, ".shift"}, 32'(o_shift_leds), 32'(sh));
    chk({tag, ".flash"}, 32'(o_flash_leds), 32'(fl));
  endtask

  logic [3:0] exp_left  [4];
  logic [3:0] exp_right [4];

  initial begin
    exp_left  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_right = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    i_reset = 1'b0; i_enable = 1'b1; i_speed_sel = 2'd0; i_dir = 1'b0; i_mode_btn = 1'b0;

    // Reset held for two edges
    cyc(1); chk_all("rst1", 1'b0, 1'b0, 4'b0001, 4'b0000);
    cyc(1); chk_all("rst2", 1'b0, 1'b0, 4'b0001, 4'b0000);
    i_reset = 1'b1;

    // Left rotation, tick every 4 cycles
    for (int k = 0; k < 4; k++) begin
      cyc(3); chk("left.gap", 32'(o_tick), 32'd0);
      cyc(1); chk_all("left.step", 1'b0, 1'b1, exp_left[k], 4'b0000);
    end

    // Right rotation with wrap
    i_dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(3); chk("right.gap", 32'(o_tick), 32'd0);
      cyc(1); chk_all("right.step", 1'b0, 1'b1, exp_right[k], 4'b0000);
    end

    // Single-cycle button pulse -> FLASH
    i_mode_btn = 1'b1;
    cyc(1); chk_all("tog1", 1'b1, 1'b0, 4'b0001, 4'b0000);
    i_mode_btn = 1'b0;
    cyc(3); chk_all("flash.gap1", 1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc(1); chk_all("flash.on",   1'b1, 1'b1, 4'b0001, 4'b1111);
    cyc(3); chk("flash.gap2", 32'(o_tick), 32'd0);
    cyc(1); chk_all("flash.off",  1'b1, 1'b1, 4'b0001, 4'b0000);

    // Button held 20 cycles -> exactly one toggle back to SHIFT
    i_mode_btn = 1'b1;
    cyc(1);  chk_all("hold.tog", 1'b0, 1'b0, 4'b0001, 4'b0000);
    cyc(19); chk_all("hold.end", 1'b0, 1'b0, 4'b0001, 4'b0000);
    i_mode_btn = 1'b0;
    cyc(1);  chk_all("release", 1'b0, 1'b1, 4'b1000, 4'b0000);

    // Speed change with count=2 above new limit 0: clear, no tick
    cyc(2); chk("pre_sel.tick", 32'(o_tick), 32'd0);
    i_speed_sel = 2'd3;
    cyc(1); chk_all("sel.clr",  1'b0, 1'b0, 4'b1000, 4'b0000);
    cyc(1); chk_all("fast.1",   1'b0, 1'b1, 4'b0100, 4'b0000);
    cyc(1); chk_all("fast.2",   1'b0, 1'b1, 4'b0010, 4'b0000);

    // Freeze with count=1 at limit 2
    i_speed_sel = 2'd1;
    cyc(1); chk("pre_frz.tick", 32'(o_tick), 32'd0);
    i_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1); chk_all("frz", 1'b0, 1'b0, 4'b0010, 4'b0000);
    end
    i_enable = 1'b1;
    cyc(1); chk("resume.gap", 32'(o_tick), 32'd0);
    cyc(1); chk_all("resume.step", 1'b0, 1'b1, 4'b0001, 4'b0000);

    // Collision: button edge on the terminal-count edge
    cyc(3); chk_all("pre_col", 1'b0, 1'b1, 4'b1000, 4'b0000);
    cyc(2); chk("pre_col.gap", 32'(o_tick), 32'd0);
    i_mode_btn = 1'b1;
    cyc(1); chk_all("col", 1'b1, 1'b0, 4'b0001, 4'b0000);
    i_mode_btn = 1'b0;
    cyc(2); chk("post_col.gap", 32'(o_tick), 32'd0);
    cyc(1); chk_all("post_col", 1'b1, 1'b1, 4'b0001, 4'b1111);

    // Reset mid-operation, button held through reset
    i_reset = 1'b0; i_mode_btn = 1'b1;
    cyc(1); chk_all("rst_mid", 1'b0, 1'b0, 4'b0001, 4'b0000);
    i_reset = 1'b1;
    cyc(1); chk_all("rst_exit", 1'b0, 1'b0, 4'b0001, 4'b0000);
    i_mode_btn = 1'b0;
    cyc(1); chk("rst_exit.gap", 32'(o_tick), 32'd0);
    cyc(1); chk_all("rst_exit.step", 1'b0, 1'b1, 4'b1000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_led_seq_ctrl
